cache_backing_mem: RTL
======================

Name: cache_backing_mem

Overview:
- Main-memory responder on the far side of the data cache; services cache line fills (reads) and line write-backs (writes).
- The cache miss controller is the initiator: it issues one line request, then moves LINE_WORDS words in a fixed-latency burst.
- Replaces the zero-latency array behind the cache so that miss timing is realistic in the simulator.

Parameters:
- DATA_W, 32, data word width in bits.
- ADDR_W, 32, byte address width.
- LINE_WORDS, 4, words per cache line; power of two, minimum 2.
- DEPTH_WORDS, 1024, storage depth in words; power of two.
- LATENCY, 4, wait cycles between request acceptance and first beat; minimum 1.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid_i  input  1  initiator presents a line request.
- req_write_i  input  1  1 = write-back, 0 = line fill; sampled with the request.
- req_addr_i  input  ADDR_W  byte address of the request; sampled with the request.
- req_ready_o  output  1  responder idle and able to accept a request.
- beat_o  output  1  one burst beat this cycle.
- beat_idx_o  output  log2(LINE_WORDS)  word-in-line index of the current beat.
- rdata_o  output  DATA_W  read word; valid when beat_o=1 and the transaction is a read.
- wdata_i  input  DATA_W  write word; sampled on every write beat.
- done_o  output  1  high on the final beat of a transaction.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset:
  - State goes to IDLE; counters clear.
  - req_ready_o=1; beat_o=0; beat_idx_o=0; rdata_o=0; done_o=0.
  - Storage contents are not cleared.
- Acceptance: a request is accepted on the edge where req_valid_i=1 and req_ready_o=1.
  - Write flag, line base (word address with low log2(LINE_WORDS) bits cleared) and requested word offset are registered at that edge.
- States: IDLE, WAIT, BURST.
  - IDLE: req_ready_o=1. On acceptance go to WAIT with wait counter = LATENCY-1.
  - WAIT: req_ready_o=0; beat_o=0. Counter decrements each cycle; at 0 go to BURST with beat counter = 0.
  - BURST: req_ready_o=0; beat_o=1 for exactly LINE_WORDS consecutive cycles.
  - After the last beat, return to IDLE; req_ready_o=1 in the following cycle.
- Latency: the first beat appears exactly LATENCY cycles after the accepting edge. req_ready_o is low for LATENCY+LINE_WORDS cycles.
- Beat order: in the base build, beat_idx_o runs 0,1,...,LINE_WORDS-1.
- Word address: mem index = (line base + beat_idx_o) mod DEPTH_WORDS. Upper address bits beyond DEPTH_WORDS are ignored (aliasing wraps silently).
- Read beat: rdata_o = mem[index], driven combinationally from the registered index within the beat cycle. rdata_o is 0 whenever beat_o=0.
- Write beat: mem[index] <= wdata_i at the end of the beat cycle.
- Read-after-write: a read issued after a write completes returns the new data.
- done_o: 1 only during the beat with beat counter = LINE_WORDS-1; single-cycle pulse.
- Request while busy: req_valid_i is ignored while req_ready_o=0. No queuing; the initiator must hold the request until it is accepted.
- Same-cycle request as done_o: not accepted, because req_ready_o=0. It is accepted at the next edge if still held.
- Reset mid-transaction:
  - The transaction is abandoned at the reset edge. No further beats or done_o.
  - Write beats already completed remain in storage.
- req_addr_i byte offset bits [1:0] are ignored.

Optional Feature:
- Macro: MEM_CRITICAL_WORD_FIRST_EN.
- Defined:
  - Read bursts start at the requested word offset and wrap modulo LINE_WORDS. Example with LINE_WORDS=4, offset 2: beat_idx_o = 2,3,0,1.
  - done_o still marks the 4th beat.
  - Write bursts are unchanged and always ordered 0..LINE_WORDS-1.
- Undefined: all bursts ordered 0..LINE_WORDS-1; the requested word offset is discarded.

Test Plan:
- Reset, then idle -> req_ready_o=1, beat_o=0, done_o=0, rdata_o=0.
- Write at addr 0x40, wdata 0xA0,0xA1,0xA2,0xA3 -> first beat 4 cycles after acceptance; done_o on 4th beat; ready high the next cycle. Then read at 0x40 -> rdata_o = 0xA0,0xA1,0xA2,0xA3, beat_idx_o 0..3.
- Hold req_valid_i high through the entire read burst -> no second acceptance until ready returns; second transaction's first beat comes LATENCY cycles after that acceptance.
- Write at 0x40 (DEPTH_WORDS=1024), then read at 0x1040 -> same line returned (aliasing at index 16).
- Assert reset on the 2nd beat of a write of 0xB0..0xB3 to 0x80 -> no further beats, ready=1. Read 0x80 -> word0=0xB0; words 1..3 keep their prior values.
- With MEM_CRITICAL_WORD_FIRST_EN, read at 0x48 after the 0x40 write -> beat_idx_o 2,3,0,1; rdata_o 0xA2,0xA3,0xA0,0xA1. Without the macro -> order 0..3.

Source files
------------

// File: rtl/cache_backing_mem.sv
// =============================================================================
// Module   : cache_backing_mem
// Function : Fixed-latency line-burst main-memory responder behind the data cache.
//            Optional macro MEM_CRITICAL_WORD_FIRST_EN: read bursts start at the
//            requested word and wrap within the line.
// Revision : 1.0  initial release
// =============================================================================
`default_nettype none

module cache_backing_mem #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int LINE_WORDS  = 4,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid_i,
  input  logic                          req_write_i,
  input  logic [ADDR_W-1:0]             req_addr_i,
  output logic                          req_ready_o,
  output logic                          beat_o,
  output logic [$clog2(LINE_WORDS)-1:0] beat_idx_o,
  output logic [DATA_W-1:0]             rdata_o,
  input  logic [DATA_W-1:0]             wdata_i,
  output logic                          done_o
);

  localparam int IDX_W  = $clog2(LINE_WORDS);
  localparam int MEM_AW = $clog2(DEPTH_WORDS);
  localparam int TAG_W  = MEM_AW - IDX_W;
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

  state_t             state;
  logic [CNT_W-1:0]   wait_cnt;
  logic [IDX_W-1:0]   beat_cnt;
  logic               is_write;
  logic [TAG_W-1:0]   line_tag;
  logic [IDX_W-1:0]   start_idx;
  logic [TAG_W-1:0]   req_tag;
  logic [MEM_AW-1:0]  mem_idx;
  logic               unused_addr;
  logic [DATA_W-1:0]  mem [DEPTH_WORDS];

  // Byte-offset bits and address bits above the storage depth alias silently.
  assign req_tag     = req_addr_i[MEM_AW+1:IDX_W+2];
  assign unused_addr = ^req_addr_i;
  assign mem_idx     = {line_tag, beat_idx_o};

`ifdef MEM_CRITICAL_WORD_FIRST_EN
  logic [IDX_W-1:0] word_off;

  always_ff @(posedge clk) begin
    if (reset) begin
      word_off <= '0;
    end else if (state == IDLE && req_valid_i && req_ready_o) begin
      word_off <= req_addr_i[IDX_W+1:2];
    end
  end

  assign start_idx = is_write ? '0 : word_off;
`else
  assign start_idx = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      beat_cnt    <= '0;
      is_write    <= 1'b0;
      line_tag    <= '0;
      req_ready_o <= 1'b1;
      beat_o      <= 1'b0;
      beat_idx_o  <= '0;
      done_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            state       <= WAIT;
            wait_cnt    <= CNT_W'(LATENCY - 1);
            is_write    <= req_write_i;
            line_tag    <= req_tag;
            req_ready_o <= 1'b0;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            state      <= BURST;
            beat_cnt   <= '0;
            beat_o     <= 1'b1;
            beat_idx_o <= start_idx;
            done_o     <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        BURST: begin
          if (beat_cnt == LAST_BEAT) begin
            state       <= IDLE;
            beat_o      <= 1'b0;
            beat_idx_o  <= '0;
            done_o      <= 1'b0;
            req_ready_o <= 1'b1;
          end else begin
            beat_cnt   <= beat_cnt + 1'b1;
            beat_idx_o <= beat_idx_o + 1'b1;
            done_o     <= ((beat_cnt + 1'b1) == LAST_BEAT);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A beat coinciding with reset is abandoned and must not reach storage.
  always_ff @(posedge clk) begin
    if (!reset && beat_o && is_write) begin
      mem[mem_idx] <= wdata_i;
    end
  end

  assign rdata_o = (beat_o && !is_write) ? mem[mem_idx] : '0;

endmodule

`default_nettype wire
